geiger_counter_gated: RTL and testbench

Multi-channel Geiger tube pulse counter with input synchronisation, per-channel non-paralysable dead time, saturating counters and an optional fixed-length gate window that latches counts-per-window. It sits between the tube discriminator pins and the LED/readout logic, replacing the single-channel free-running counter. Gated mode yields a count rate directly; free-run mode gives a running total.

---
 rtl/geiger_counter_gated.sv | 128 ++++++++++++
 tb/tb_geiger_counter_gated.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/geiger_counter_gated.sv
// Multi-channel Geiger tube pulse counter: input synchronisers, non-paralysable
// dead time, saturating counters, and an optional fixed gate window.
module geiger_counter_gated #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 16,
    parameter int DEAD_CYCLES = 5000,
    parameter int GATE_CYCLES = 50_000_000
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         geiger,
    input  logic                    gated,
    input  logic                    clear,
    output logic [N_CH*CNT_W-1:0]   count,
    output logic                    valid,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH-1:0]         dead
);

    localparam int DEAD_W = $clog2(DEAD_CYCLES);
    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              gated_q;
    logic [GATE_W-1:0] gate_tmr;
    logic              mode_chg;
    logic              clr;
    logic              close;

    // A mode switch behaves exactly like an explicit clear.
    assign mode_chg = gated ^ gated_q;
    assign clr      = clear | mode_chg;
    assign close    = gated & ~clr & (gate_tmr == GATE_LAST);

    // valid is a bare one-cycle strobe: there is no ready, and a consumer that
    // misses it simply reads the held count until the next window closes.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            gated_q  <= 1'b0;
            gate_tmr <= '0;
            valid    <= 1'b0;
        end else begin
            gated_q <= gated;
            valid   <= close;
            if (!gated || clr) begin
                gate_tmr <= '0;
            end else if (gate_tmr == GATE_LAST) begin
                gate_tmr <= '0;
            end else begin
                gate_tmr <= gate_tmr + GATE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              s1;
        logic              s2;
        logic              s3;
        logic              edge_q;
        logic [DEAD_W-1:0] dtmr;
        logic [CNT_W-1:0]  live;
        logic [CNT_W-1:0]  live_inc;
        logic [CNT_W-1:0]  cnt_q;
        logic              ovf_q;
        logic              ovf_drop;
        logic              dead_q;
        logic              accept;
        logic              sat_hit;

        assign accept   = edge_q & (dtmr == '0);
        assign sat_hit  = accept & (live == {CNT_W{1'b1}});
        assign live_inc = (accept && !sat_hit) ? live + CNT_W'(1) : live;

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                s3       <= 1'b0;
                edge_q   <= 1'b0;
                dtmr     <= '0;
                dead_q   <= 1'b0;
                live     <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
                ovf_drop <= 1'b0;
            end else begin
                s1     <= geiger[i];
                s2     <= s1;
                s3     <= s2;
                edge_q <= s2 & ~s3;

                // Dead time runs regardless of clear so a lost edge still blanks.
                if (accept) begin
                    dtmr <= DEAD_LOAD;
                end else if (dtmr != '0) begin
                    dtmr <= dtmr - DEAD_W'(1);
                end
                dead_q <= accept | (dtmr != '0);

                if (clr) begin
                    live     <= '0;
                    ovf_q    <= 1'b0;
                    ovf_drop <= 1'b0;
                end else if (close) begin
                    live     <= '0;
                    ovf_q    <= sat_hit;
                    ovf_drop <= sat_hit;
                end else begin
                    live     <= live_inc;
                    ovf_q    <= (ovf_q & ~ovf_drop) | sat_hit;
                    ovf_drop <= 1'b0;
                end

                if (!gated) begin
                    cnt_q <= live;
                end else if (close) begin
                    cnt_q <= live_inc;
                end
            end
        end

        assign count[i*CNT_W +: CNT_W] = cnt_q;
        assign ovf[i]                  = ovf_q;
        assign dead[i]                 = dead_q;
    end

endmodule

// File: tb/tb_geiger_counter_gated.sv
// Directed bench for geiger_counter_gated: free-run, dead time, gated windows,
// closing-cycle edge, saturation with a narrow counter, clear and reset.
module tb_geiger_counter_gated;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [1:0]  geiger;
    logic        gated;
    logic        clear;
    logic [31:0] count;
    logic        valid;
    logic [1:0]  ovf;
    logic [1:0]  dead;

    logic [1:0]  geiger4;
    logic        gated4;
    logic        clear4;
    logic [7:0]  count4;
    logic        valid4;
    logic [1:0]  ovf4;
    logic [1:0]  dead4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    geiger_counter_gated #(
        .N_CH(2), .CNT_W(16), .DEAD_CYCLES(8), .GATE_CYCLES(100)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .geiger(geiger), .gated(gated),
        .clear(clear), .count(count), .valid(valid), .ovf(ovf), .dead(dead)
    );

    geiger_counter_gated #(
        .N_CH(2), .CNT_W(4), .DEAD_CYCLES(8), .GATE_CYCLES(100)
    ) dut4 (
        .sys_clk(sys_clk), .rst(rst), .geiger(geiger4), .gated(gated4),
        .clear(clear4), .count(count4), .valid(valid4), .ovf(ovf4), .dead(dead4)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse0(input int hi, input int lo);
        geiger[0] = 1'b1;
        repeat (hi) step();
        geiger[0] = 1'b0;
        repeat (lo) step();
    endtask

    task automatic pulse4(input int hi, input int lo);
        geiger4[0] = 1'b1;
        repeat (hi) step();
        geiger4[0] = 1'b0;
        repeat (lo) step();
    endtask

    // Returns the number of steps taken until valid is seen, bounded by budget.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < budget);
        check_eq("valid_seen", 32'(valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int vseen;

        rst     = 1'b1;
        gated   = 1'b0;
        clear   = 1'b0;
        geiger  = 2'b00;
        gated4  = 1'b0;
        clear4  = 1'b0;
        geiger4 = 2'b00;
        repeat (3) step();
        rst = 1'b0;

        check_eq("rst_count", count, 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_dead", 32'(dead), 32'd0);
        check_eq("rst_count4", 32'(count4), 32'd0);
        step();

        // Single 3-cycle pulse on ch0, rising edge sampled at t.
        geiger[0] = 1'b1;
        step(); step(); step();
        geiger[0] = 1'b0;
        check_eq("dead_t2", 32'(dead[0]), 32'd0);
        step();
        check_eq("dead_t3", 32'(dead[0]), 32'd1);
        check_eq("count_t3", 32'(count[15:0]), 32'd0);
        step();
        check_eq("count_t4", 32'(count[15:0]), 32'd1);
        repeat (6) step();
        check_eq("dead_t10", 32'(dead[0]), 32'd1);
        step();
        check_eq("dead_t11", 32'(dead[0]), 32'd0);
        check_eq("ch1_idle", 32'(count[31:16]), 32'd0);

        // Spacing 5 with dead time 8: every other pulse counted.
        repeat (10) pulse0(2, 3);
        repeat (10) step();
        check_eq("spacing5", 32'(count[15:0]), 32'd6);

        // Spacing exactly 8: all pulses counted.
        repeat (10) pulse0(3, 5);
        repeat (10) step();
        check_eq("spacing8", 32'(count[15:0]), 32'd16);

        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check_eq("frun_clear", count, 32'd0);

        // Gated: 7 pulses on ch0 and 3 on ch1 in the first window.
        gated = 1'b1;
        for (int i = 0; i < 7; i++) begin
            geiger[0] = 1'b1;
            if (i < 3) geiger[1] = 1'b1;
            repeat (3) step();
            geiger = 2'b00;
            repeat (6) step();
        end
        wait_valid(150, n);
        check_eq("win1_count", count, {16'd3, 16'd7});
        step();
        check_eq("valid_one_cycle", 32'(valid), 32'd0);
        wait_valid(150, n);
        check_eq("win_len", 32'(n + 1), 32'd100);
        check_eq("win2_count", count, 32'd0);

        // Edge accepted in the closing cycle (timer = 99) lands in that window.
        repeat (96) step();
        geiger[0] = 1'b1;
        repeat (3) step();
        geiger[0] = 1'b0;
        wait_valid(150, n);
        check_eq("close_latency", 32'(n), 32'd1);
        check_eq("close_count", count, {16'd0, 16'd1});
        check_eq("close_dead", 32'(dead[0]), 32'd1);
        wait_valid(150, n);
        check_eq("next_win_len", 32'(n), 32'd100);
        check_eq("next_win_count", count, 32'd0);

        // Back to free-run, then clear in the same cycle as a ch1 acceptance.
        gated = 1'b0;
        repeat (12) step();
        check_eq("frun_again", count, 32'd0);
        pulse0(3, 9);
        check_eq("frun_one", 32'(count[15:0]), 32'd1);
        geiger[1] = 1'b1;
        step(); step(); step();
        geiger[1] = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_dead", 32'(dead[1]), 32'd1);
        step(); step();
        check_eq("clr_edge_lost", count, 32'd0);

        // Reset in the middle of a gated window.
        gated = 1'b1;
        repeat (40) step();
        geiger[0] = 1'b1;
        repeat (3) step();
        geiger[0] = 1'b0;
        step();
        check_eq("pre_rst_dead", 32'(dead[0]), 32'd1);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_eq("mid_rst_count", count, 32'd0);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
        check_eq("mid_rst_dead", 32'(dead), 32'd0);
        vseen = 0;
        repeat (80) begin
            step();
            if (valid) vseen++;
        end
        check_eq("no_valid_after_rst", 32'(vseen), 32'd0);
        gated = 1'b0;

        // 4-bit counter saturation.
        repeat (15) pulse4(3, 6);
        check_eq("sat15_count", 32'(count4[3:0]), 32'd15);
        check_eq("sat15_ovf", 32'(ovf4[0]), 32'd0);
        pulse4(3, 6);
        check_eq("sat16_count", 32'(count4[3:0]), 32'd15);
        check_eq("sat16_ovf", 32'(ovf4[0]), 32'd1);
        pulse4(3, 6);
        check_eq("sat17_count", 32'(count4[3:0]), 32'd15);
        check_eq("sat17_ovf", 32'(ovf4[0]), 32'd1);
        check_eq("sat_ch1", 32'(count4[7:4]), 32'd0);
        clear4 = 1'b1;
        step();
        clear4 = 1'b0;
        step();
        check_eq("sat_clr_count", 32'(count4), 32'd0);
        check_eq("sat_clr_ovf", 32'(ovf4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
